// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - pattern/enable inputs and scanned pin outputs of seg7_scan
interface seg7_scan_if;
  logic        en;
  logic [63:0] digits;
  logic [7:0]  blank;
  logic [7:0]  seg;
  logic [7:0]  dig;
  logic [2:0]  dig_idx;
  logic        frame_tick;

  modport master (
    output en, digits, blank,
    input  seg, dig, dig_idx, frame_tick
  );

  modport slave (
    input  en, digits, blank,
    output seg, dig, dig_idx, frame_tick
  );
endinterface

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - time-multiplexed 8-digit 7-segment scanner with frame snapshot
module seg7_scan #(
  parameter int DIV            = 50000,
  parameter int BLANK          = 2,
  parameter int NDIG           = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  seg7_scan_if.slave  bus
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [7:0] SEG_MASK = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0] DIG_MASK = DIG_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [63:0]      snap_q, snap_d;
  logic [7:0]       bsnap_q, bsnap_d;
  logic             tick_q, tick_d;
  logic [7:0]       seg_raw_q, seg_raw_d;
  logic [7:0]       dig_raw_q, dig_raw_d;
  logic             lit_d;
  logic             drive;

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    bsnap_d = bsnap_q;
    tick_d  = 1'b0;
    if (rst) begin
      cnt_d   = '0;
      idx_d   = '0;
      snap_d  = bus.digits;
      bsnap_d = bus.blank;
    end else if (bus.en) begin
      if (cnt_q != CNT_W'(DIV - 1)) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
        if (idx_q != 3'(NDIG - 1)) begin
          idx_d = idx_q + 3'd1;
        end else begin
          // Frame wrap: capture a fresh, tear-free copy of patterns and mask.
          idx_d   = '0;
          snap_d  = bus.digits;
          bsnap_d = bus.blank;
          tick_d  = 1'b1;
        end
      end
    end
  end

  // Pin patterns are precomputed from next state so they come straight off flops.
  always_comb begin
    lit_d     = (int'(cnt_d) >= BLANK) && !bsnap_d[idx_d];
    seg_raw_d = lit_d ? snap_d[{idx_d, 3'b000} +: 8] : 8'h00;
    dig_raw_d = lit_d ? (8'b1 << idx_d) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      tick_q    <= tick_d;
    end
    snap_q    <= snap_d;
    bsnap_q   <= bsnap_d;
    seg_raw_q <= seg_raw_d;
    dig_raw_q <= dig_raw_d;
  end

  // Disable and reset darken the pins immediately without disturbing the scan state.
  assign drive          = bus.en & ~rst;
  assign bus.seg        = (drive ? seg_raw_q : 8'h00) ^ SEG_MASK;
  assign bus.dig        = (drive ? dig_raw_q : 8'h00) ^ DIG_MASK;
  assign bus.dig_idx    = rst ? 3'd0 : idx_q;
  assign bus.frame_tick = tick_q & drive;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - self-checking bench for seg7_scan with a slot-position model
module tb_seg7_scan;

  localparam int DIVV [2] = '{4, 4};
  localparam int BLV  [2] = '{1, 0};
  localparam int NDV  [2] = '{8, 4};
  localparam bit SALV [2] = '{1'b1, 1'b0};
  localparam bit DALV [2] = '{1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [63:0] digits;
  logic [7:0]  blank;

  int checks = 0;
  int errors = 0;

  seg7_scan_if if0 ();
  seg7_scan_if if1 ();

  assign if0.en = en;
  assign if0.digits = digits;
  assign if0.blank = blank;
  assign if1.en = en;
  assign if1.digits = digits;
  assign if1.blank = blank;

  seg7_scan #(.DIV(4), .BLANK(1), .NDIG(8), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  seg7_scan #(.DIV(4), .BLANK(0), .NDIG(4), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: position within the frame counts enabled cycles since reset.
  int          mpos  [2];
  logic [63:0] msnap [2];
  logic [7:0]  mbsnap[2];
  bit          mtick [2];
  bit          armed = 1'b0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mpos[d]   = 0;
        msnap[d]  = digits;
        mbsnap[d] = blank;
        mtick[d]  = 1'b0;
      end else if (en) begin
        mpos[d] = (mpos[d] + 1) % (DIVV[d] * NDV[d]);
        mtick[d] = (mpos[d] == 0);
        if (mpos[d] == 0) begin
          msnap[d]  = digits;
          mbsnap[d] = blank;
        end
      end else begin
        mtick[d] = 1'b0;
      end
    end
    if (rst) armed = 1'b1;
  end

  task automatic model_out(input int d, output logic [7:0] s, output logic [7:0] g,
                           output logic [2:0] ix, output logic tk);
    int slot, phase;
    bit act;
    slot  = mpos[d] / DIVV[d];
    phase = mpos[d] % DIVV[d];
    act   = en && !rst && (phase >= BLV[d]) && !mbsnap[d][slot];
    s  = act ? msnap[d][slot*8 +: 8] : 8'h00;
    g  = act ? (8'h01 << slot) : 8'h00;
    if (SALV[d]) s = ~s;
    if (DALV[d]) g = ~g;
    ix = rst ? 3'd0 : 3'(slot);
    tk = mtick[d] && en && !rst;
  endtask

  always @(negedge clk) begin
    logic [7:0] es, eg;
    logic [2:0] ei;
    logic       et;
    if (armed) begin
      model_out(0, es, eg, ei, et);
      chk("dut0 seg", if0.seg, es);
      chk("dut0 dig", if0.dig, eg);
      chk("dut0 dig_idx", if0.dig_idx, ei);
      chk("dut0 frame_tick", if0.frame_tick, et);
      model_out(1, es, eg, ei, et);
      chk("dut1 seg", if1.seg, es);
      chk("dut1 dig", if1.dig, eg);
      chk("dut1 dig_idx", if1.dig_idx, ei);
      chk("dut1 frame_tick", if1.frame_tick, et);
    end
  end

  initial begin
    int ticks = 0;
    rst    = 1'b1;
    en     = 1'b1;
    digits = 64'hE0BE_B666_F2DA_60FC;
    blank  = 8'h00;

    repeat (3) begin
      @(posedge clk); #4;
      chk("reset seg", if0.seg, 8'hFF);
      chk("reset dig", if0.dig, 8'hFF);
      chk("reset dig_idx", if0.dig_idx, 3'd0);
      chk("reset tick", if0.frame_tick, 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    for (int c = 0; c <= 200; c++) begin
      case (c)
        42:  digits[7:0] = 8'h60;
        100: blank = 8'h04;
        141: en = 1'b0;
        146: en = 1'b1;
        154: rst = 1'b1;
        155: rst = 1'b0;
        default: ;
      endcase
      #3;
      if (c >= 1 && c <= 127 && if0.frame_tick) ticks++;
      case (c)
        0: begin
          chk("c0 dig", if0.dig, 8'hFF);
          chk("c0 seg", if0.seg, 8'hFF);
          chk("pol dig", if1.dig, 8'h01);
          chk("pol seg", if1.seg, 8'hFC);
        end
        1, 2, 3: begin
          chk("slot0 dig", if0.dig, 8'hFE);
          chk("slot0 seg", if0.seg, 8'h03);
        end
        4: chk("gap dig", if0.dig, 8'hFF);
        5, 6, 7: begin
          chk("slot1 dig", if0.dig, 8'hFD);
          chk("slot1 seg", if0.seg, 8'h9F);
        end
        32, 64, 96: begin
          chk("wrap tick", if0.frame_tick, 1'b1);
          chk("wrap idx", if0.dig_idx, 3'd0);
        end
        33: chk("snap old seg", if0.seg, 8'h03);
        65: chk("snap new seg", if0.seg, 8'h9F);
        137: chk("blanked dig", if0.dig, 8'hFF);
        143: begin
          chk("en0 dig", if0.dig, 8'hFF);
          chk("en0 idx", if0.dig_idx, 3'd3);
        end
        146: chk("resume dig", if0.dig, 8'hF7);
        148: chk("resume idx", if0.dig_idx, 3'd3);
        149: chk("next slot idx", if0.dig_idx, 3'd4);
        154: chk("rst idx", if0.dig_idx, 3'd0);
        155: begin
          chk("post rst idx", if0.dig_idx, 3'd0);
          chk("post rst dig", if0.dig, 8'hFF);
        end
        default: ;
      endcase
      if (c == 127) chk("tick count", ticks, 3);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Time-multiplexed driver for the board's 8-digit 7-segment display.
- Consumes per-digit segment patterns, as produced by the 7-segment decoders and the 8:1 byte mux path, and scans them onto shared segment lines plus one-hot digit enables.
- Provides a clock prescaler, anti-ghosting blanking, per-digit blanking and frame-coherent snapshot buffering.

Parameters:
- DIV, 50000, clock cycles per digit slot; must be ≥2.
- BLANK, 2, cycles at the start of each slot with all digits off; must satisfy 0 ≤ BLANK < DIV.
- NDIG, 8, number of digits scanned, 1..8.
- SEG_ACTIVE_LOW, 1, 1 = seg pins low-active.
- DIG_ACTIVE_LOW, 1, 1 = dig pins low-active.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  scan enable
- digits  in  64  8 patterns; digit k = digits[8k+7:8k]; bit7..bit1 = segments a..g, bit0 = dp; 1 = lit
- blank  in  8  per-digit blank mask; 1 = digit k dark
- seg  out  8  segment pins, same bit order as a digit byte, polarity per SEG_ACTIVE_LOW
- dig  out  8  digit enables, one-hot; bit k = digit k; polarity per DIG_ACTIVE_LOW
- dig_idx  out  3  index of the current slot
- frame_tick  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- State: prescaler cnt (0..DIV-1), slot index idx (0..NDIG-1), snapshot registers snap[63:0] and bsnap[7:0].
- While rst=1:
  - cnt=0, idx=0.
  - snap<=digits and bsnap<=blank every cycle.
  - Outputs: seg all inactive, dig all inactive (8'hFF for active-low defaults), dig_idx=0, frame_tick=0.
- Clock edge with rst=0, en=1:
  - cnt≠DIV-1: cnt<=cnt+1.
  - cnt=DIV-1, idx≠NDIG-1: cnt<=0, idx<=idx+1.
  - cnt=DIV-1, idx=NDIG-1 (wrap): cnt<=0, idx<=0, snap<=digits, bsnap<=blank, frame_tick<=1.
  - frame_tick is 0 on every other edge, so it is high exactly in the first cycle of each frame (cnt=0, idx=0). There is no tick on reset release.
- en=0:
  - cnt, idx and snap hold.
  - seg and dig are all inactive; frame_tick=0.
  - On re-enable the scan resumes from the held cnt and idx.
- Output function, registered and glitch-free:
  - The value in any cycle is a function of that same cycle's cnt, idx, snap and bsnap.
  - dig_idx = idx.
  - Digit k is active iff en=1, k=idx, cnt≥BLANK and bsnap[k]=0.
  - When no digit is active, seg is all inactive.
  - Otherwise seg = snap byte idx, inverted if SEG_ACTIVE_LOW.
  - dig bits [7:NDIG] are always inactive.
- Snapshot: mid-frame changes on digits or blank have no visible effect until the next wrap. No tearing within a frame.
- Frame period = NDIG×DIV cycles. The lit duty per digit is (DIV-BLANK)/(NDIG×DIV).
- BLANK=0: no inter-digit gap, and the digit is lit from cnt=0.
- Reset mid-operation: the next cycle shows the reset values; the scan restarts at idx 0.
- Simultaneous rst and en: rst wins.

Test Plan (DIV=4, BLANK=1, NDIG=8, active-low defaults unless stated):
- Reset: rst=1 for 3 cycles, en=1 → seg=8'hFF, dig=8'hFF, dig_idx=0, frame_tick=0 in every cycle.
- Basic scan: digits byte0=8'hFC, byte1=8'h60, blank=0, release rst.
  - Cycle 0: dig=8'hFF, seg=8'hFF.
  - Cycles 1..3: dig=8'hFE, seg=8'h03.
  - Cycle 4: dig=8'hFF.
  - Cycles 5..7: dig=8'hFD, seg=8'h9F.
- Wrap and tick: run 3 frames.
  - frame_tick high for exactly 1 cycle every 32 cycles, coinciding with dig_idx 7→0.
  - dig is never multi-hot.
- Snapshot: change byte0 to 8'h60 at cycle 10 of a frame → slot 0 shows seg=8'h03 until the next frame_tick, then seg=8'h9F.
- Blank mask and en: blank=8'h04 → slot 2 keeps dig=8'hFF for all 4 cycles. Drop en for 5 cycles in slot 3 → outputs inactive, dig_idx stays 3, and the slot completes its remaining cycles after en returns.
- Reset mid-frame and polarity: assert rst in slot 5 → next cycle dig_idx=0, dig=8'hFF. With SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=0, NDIG=4 → slot 0 lit gives dig=8'h01 and seg=8'hFC, and dig[7:4] stays 0.
